i2cm_reg_seq: RTL and testbench

Synthesizable I2C register-access sequencer that sits between an on-chip requester (CPU or register bridge) and a byte-level I2C master engine. It turns one register request (device address, register address, 1/2/4/8-byte write or read) into the exact byte-command sequence the I2C slave register block expects:
- Write: START + device/W, register, data bytes, STOP.
- Read: START + device/W, register, STOP; then START + device/R, data bytes with ACK, last byte NACK, STOP.

It reports completion, read data and error class back to the requester.

---
 rtl/i2cm_pkg.sv | 50 +++++
 rtl/i2cm_reg_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2cm_reg_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2cm_pkg.sv
// Shared definitions for the I2C register-access sequencer:
// state encoding, response error codes, length encodings and
// command-bit positions of the byte-engine command vector.
package i2cm_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_W,
        S_REG,
        S_WDATA,
        S_STOP1,
        S_ADDR_R,
        S_RDATA,
        S_STOP,
        S_STOP_ERR,
        S_STOP_RTY,
        S_DONE
    } state_t;

    localparam logic [1:0] I2CM_OK    = 2'b00;
    localparam logic [1:0] I2CM_ANACK = 2'b01;
    localparam logic [1:0] I2CM_DNACK = 2'b10;
    localparam logic [1:0] I2CM_AL    = 2'b11;

    localparam logic [1:0] LEN_1 = 2'd0;
    localparam logic [1:0] LEN_2 = 2'd1;
    localparam logic [1:0] LEN_4 = 2'd2;
    localparam logic [1:0] LEN_8 = 2'd3;

    localparam int unsigned CMD_START = 0;
    localparam int unsigned CMD_STOP  = 1;
    localparam int unsigned CMD_WRITE = 2;
    localparam int unsigned CMD_READ  = 3;
    localparam int unsigned CMD_ACKIN = 4;
    localparam int unsigned CMD_W     = 5;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic start, input logic stop,
                                                 input logic write, input logic read,
                                                 input logic ack_in);
        logic [CMD_W-1:0] c;
        c            = '0;
        c[CMD_START] = start;
        c[CMD_STOP]  = stop;
        c[CMD_WRITE] = write;
        c[CMD_READ]  = read;
        c[CMD_ACKIN] = ack_in;
        return c;
    endfunction

endpackage

// File: rtl/i2cm_reg_seq.sv
// I2C register-access sequencer: turns one register read/write request
// into the byte-command sequence for a byte-level I2C master engine.
// Optional address-NACK retry enabled by defining I2CM_SEQ_RETRY_EN.
module i2cm_reg_seq
    import i2cm_pkg::*;
#(
    parameter int unsigned RETRY_CNT = 3
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [6:0]  req_dev,
    input  logic [7:0]  req_reg,
    input  logic [1:0]  req_len,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_err,
    output logic [63:0] rsp_rdata,
    output logic        bc_start,
    output logic        bc_stop,
    output logic        bc_write,
    output logic        bc_read,
    output logic        bc_ack_in,
    output logic [7:0]  bc_din,
    input  logic        bc_cmd_ack,
    input  logic        bc_ack_out,
    input  logic [7:0]  bc_dout,
    input  logic        bc_al
);

    // The retry counter is 4 bits wide; larger settings cannot be honoured.
    if (RETRY_CNT > 15) begin : g_retry_range
        $error("RETRY_CNT must not exceed 15");
    end

    state_t           state_q, state_n;
    logic [CMD_W-1:0] cmd_q, cmd_n;
    logic [7:0]       din_q, din_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [63:0]      sh_q, sh_n;
    logic [63:0]      rdata_q, rdata_n;
    logic [1:0]       err_q, err_n;
    logic             wr_q, wr_n;
    logic [6:0]       dev_q, dev_n;
    logic [7:0]       reg_q, reg_n;
    logic             cmd_busy;
    logic             last;

`ifdef I2CM_SEQ_RETRY_EN
    logic [3:0]       retry_q, retry_n;
    logic             retry_ok;
    assign retry_ok = retry_q < 4'(RETRY_CNT);
`endif

    assign cmd_busy = cmd_q[CMD_START] | cmd_q[CMD_STOP] | cmd_q[CMD_WRITE] | cmd_q[CMD_READ];
    assign last     = (cnt_q == 4'd1);

    // Next-state, command generation and datapath updates.
    // A command is issued only when none is active, so after an ack clears
    // the command the following command appears one idle cycle later.
    always_comb begin
        state_n = state_q;
        cmd_n   = cmd_q;
        din_n   = din_q;
        cnt_n   = cnt_q;
        sh_n    = sh_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        wr_n    = wr_q;
        dev_n   = dev_q;
        reg_n   = reg_q;
`ifdef I2CM_SEQ_RETRY_EN
        retry_n = retry_q;
`endif
        if (bc_al && state_q != S_IDLE && state_q != S_DONE) begin
            cmd_n   = '0;
            err_n   = I2CM_AL;
            state_n = S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_n    = req_wr;
                        dev_n   = req_dev;
                        reg_n   = req_reg;
                        cnt_n   = 4'd1 << req_len;
                        rdata_n = '0;
                        err_n   = I2CM_OK;
                        // Left-align the active bytes so the MSB byte goes first.
                        case (req_len)
                            LEN_1:   sh_n = {req_wdata[7:0],  56'h0};
                            LEN_2:   sh_n = {req_wdata[15:0], 48'h0};
                            LEN_4:   sh_n = {req_wdata[31:0], 32'h0};
                            default: sh_n = req_wdata;
                        endcase
`ifdef I2CM_SEQ_RETRY_EN
                        retry_n = '0;
`endif
                        state_n = S_ADDR_W;
                    end
                end
                S_ADDR_W, S_ADDR_R: begin
                    if (!cmd_busy) begin
                        cmd_n = mk_cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                        din_n = {dev_q, (state_q == S_ADDR_R)};
                    end else if (bc_cmd_ack) begin
                        cmd_n = '0;
                        if (!bc_ack_out) begin
                            state_n = (state_q == S_ADDR_R) ? S_RDATA : S_REG;
                        end else begin
`ifdef I2CM_SEQ_RETRY_EN
                            if (retry_ok) begin
                                retry_n = retry_q + 4'd1;
                                state_n = S_STOP_RTY;
                            end else
`endif
                            begin
                                err_n   = I2CM_ANACK;
                                state_n = S_STOP_ERR;
                            end
                        end
                    end
                end
                S_REG: begin
                    if (!cmd_busy) begin
                        cmd_n = mk_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                        din_n = reg_q;
                    end else if (bc_cmd_ack) begin
                        cmd_n = '0;
                        if (bc_ack_out) begin
                            err_n   = I2CM_DNACK;
                            state_n = S_STOP_ERR;
                        end else begin
                            state_n = wr_q ? S_WDATA : S_STOP1;
                        end
                    end
                end
                S_WDATA: begin
                    if (!cmd_busy) begin
                        cmd_n = mk_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                        din_n = sh_q[63:56];
                        sh_n  = {sh_q[55:0], 8'h00};
                    end else if (bc_cmd_ack) begin
                        cmd_n = '0;
                        cnt_n = cnt_q - 4'd1;
                        if (bc_ack_out) begin
                            err_n   = I2CM_DNACK;
                            state_n = S_STOP_ERR;
                        end else if (last) begin
                            state_n = S_STOP;
                        end
                    end
                end
                S_RDATA: begin
                    if (!cmd_busy) begin
                        cmd_n = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, last);
                    end else if (bc_cmd_ack) begin
                        cmd_n   = '0;
                        cnt_n   = cnt_q - 4'd1;
                        rdata_n = {rdata_q[55:0], bc_dout};
                        if (last) begin
                            state_n = S_STOP;
                        end
                    end
                end
                S_STOP1, S_STOP, S_STOP_ERR, S_STOP_RTY: begin
                    if (!cmd_busy) begin
                        cmd_n = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    end else if (bc_cmd_ack) begin
                        cmd_n = '0;
                        case (state_q)
                            S_STOP1:    state_n = S_ADDR_R;
                            S_STOP_RTY: state_n = S_ADDR_W;
                            default:    state_n = S_DONE;
                        endcase
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    cmd_n   = '0;
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
            err_q   <= I2CM_OK;
            wr_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_n;
            cmd_q   <= cmd_n;
            din_q   <= din_n;
            cnt_q   <= cnt_n;
            sh_q    <= sh_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
            wr_q    <= wr_n;
            dev_q   <= dev_n;
            reg_q   <= reg_n;
        end
    end

`ifdef I2CM_SEQ_RETRY_EN
    // Address-phase retry counter, cleared on each accepted request.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_n;
        end
    end
`endif

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;
    assign bc_start  = cmd_q[CMD_START];
    assign bc_stop   = cmd_q[CMD_STOP];
    assign bc_write  = cmd_q[CMD_WRITE];
    assign bc_read   = cmd_q[CMD_READ];
    assign bc_ack_in = cmd_q[CMD_ACKIN];
    assign bc_din    = din_q;

endmodule

// File: tb/tb_i2cm_reg_seq.sv
// Scoreboard bench for i2cm_reg_seq with a byte-engine model.
module tb_i2cm_reg_seq;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wr;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [1:0]  req_len;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic [63:0] rsp_rdata;
    logic        bc_start, bc_stop, bc_write, bc_read, bc_ack_in;
    logic [7:0]  bc_din;
    logic        bc_cmd_ack, bc_ack_out, bc_al;
    logic [7:0]  bc_dout;

    i2cm_reg_seq #(.RETRY_CNT(3)) dut (
        .mclk(mclk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .bc_start(bc_start), .bc_stop(bc_stop), .bc_write(bc_write), .bc_read(bc_read),
        .bc_ack_in(bc_ack_in), .bc_din(bc_din),
        .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al)
    );

    always #5 mclk = ~mclk;

    // command vector order: {start, stop, write, read, ack_in}
    localparam logic [4:0] K_SW = 5'b10100;
    localparam logic [4:0] K_W  = 5'b00100;
    localparam logic [4:0] K_RA = 5'b00010;
    localparam logic [4:0] K_RN = 5'b00011;
    localparam logic [4:0] K_P  = 5'b01000;

    typedef struct { logic [4:0] bits; logic [7:0] din; } cmd_t;
    typedef struct { logic ack; logic [7:0] dout; logic al; } eng_t;
    typedef struct { logic [1:0] err; logic [63:0] rdata; } rsp_t;

    cmd_t exp_cmd[$];
    eng_t plan[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic ex(input logic [4:0] bits, input logic [7:0] din, input logic ack,
                      input logic [7:0] dout, input logic al);
        cmd_t c;
        eng_t e;
        c.bits = bits; c.din = din;
        e.ack = ack; e.dout = dout; e.al = al;
        exp_cmd.push_back(c);
        plan.push_back(e);
    endtask

    // Byte-engine model: records each new command against the scoreboard,
    // checks it is held, acks it two cycles later and checks the idle gap.
    initial begin : engine
        logic [4:0] cur, held;
        logic [7:0] held_din;
        bit  busy, after_ack;
        int  lat, gap;
        cmd_t c;
        eng_t e;
        bc_cmd_ack = 1'b0; bc_al = 1'b0; bc_ack_out = 1'b0; bc_dout = 8'h00;
        busy = 0; after_ack = 0; lat = 0; gap = 0; held = '0; held_din = '0;
        forever begin
            @(posedge mclk); #1;
            bc_cmd_ack = 1'b0;
            bc_al      = 1'b0;
            if (!reset_n) begin
                busy = 0; after_ack = 0;
                continue;
            end
            if (rsp_valid) after_ack = 0;
            cur = {bc_start, bc_stop, bc_write, bc_read, bc_ack_in};
            if (busy) begin
                check("cmd_hold", {cur, bc_din}, {held, held_din});
                if (lat == 0) begin
                    if (plan.size() > 0) e = plan.pop_front();
                    else begin e.ack = 1'b0; e.dout = 8'h00; e.al = 1'b0; end
                    bc_cmd_ack = 1'b1;
                    bc_ack_out = e.ack;
                    bc_dout    = e.dout;
                    bc_al      = e.al;
                    busy = 0; after_ack = 1; gap = 0;
                end else begin
                    lat--;
                end
            end else if (cur[4:1] != 4'b0000) begin
                if (after_ack) check("cmd_gap", 64'(gap), 64'd1);
                if (exp_cmd.size() == 0) begin
                    fail_now($sformatf("unexpected_cmd bits=%b din=0x%0h", cur, bc_din));
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_bits", 64'(cur), 64'(c.bits));
                    if (c.bits[2]) check("cmd_din", 64'(bc_din), 64'(c.din));
                end
                held = cur; held_din = bc_din; busy = 1; lat = 1;
            end else if (after_ack) begin
                gap++;
            end
        end
    end

    // Response monitor.
    initial begin : monitor
        rsp_t r;
        forever begin
            @(posedge mclk); #1;
            if (reset_n && rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    fail_now("unexpected_rsp_valid");
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_err", 64'(rsp_err), 64'(r.err));
                    check("rsp_rdata", rsp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [1:0] len, input logic [63:0] wdata);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge mclk); #1; n++; end
        if (!req_ready) fail_now("req_ready_timeout");
        req_wr = wr; req_dev = dev; req_reg = rg; req_len = len; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge mclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_req(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [1:0] len, input logic [63:0] wdata,
                           input logic [1:0] err, input logic [63:0] rdata);
        rsp_t r;
        int n;
        r.err = err; r.rdata = rdata;
        exp_rsp.push_back(r);
        issue(wr, dev, rg, len, wdata);
        n = 0;
        while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && n < 1000) begin
            @(posedge mclk); #3; n++;
        end
        if (exp_rsp.size() != 0 || exp_cmd.size() != 0) begin
            fail_now("transaction_timeout");
            exp_rsp.delete(); exp_cmd.delete();
        end
        plan.delete();
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {req_ready, rsp_valid, rsp_err, bc_start, bc_stop, bc_write, bc_read,
                     bc_ack_in, bc_din}, {1'b1, 1'b0, 2'b00, 5'b00000, 8'h00});
        check({name, "_rdata"}, rsp_rdata, 64'h0);
    endtask

    initial begin : stim
        int n;
        reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_dev = '0; req_reg = '0;
        req_len = '0; req_wdata = '0;
        #23;
        check_reset_vals("reset_state");
        #4 reset_n = 1'b1;
        repeat (2) @(posedge mclk);
        #1;

        // 1-byte write
        ex(K_SW, 8'h94, 0, 0, 0); ex(K_W, 8'h10, 0, 0, 0); ex(K_W, 8'h5A, 0, 0, 0); ex(K_P, 0, 0, 0, 0);
        run_req(1'b1, 7'h4A, 8'h10, 2'd0, 64'h5A, 2'b00, 64'h0);

        // 4-byte read
        ex(K_SW, 8'h94, 0, 0, 0); ex(K_W, 8'h20, 0, 0, 0); ex(K_P, 0, 0, 0, 0);
        ex(K_SW, 8'h95, 0, 0, 0);
        ex(K_RA, 0, 0, 8'h11, 0); ex(K_RA, 0, 0, 8'h22, 0); ex(K_RA, 0, 0, 8'h33, 0);
        ex(K_RN, 0, 0, 8'h44, 0); ex(K_P, 0, 0, 0, 0);
        run_req(1'b0, 7'h4A, 8'h20, 2'd2, 64'h0, 2'b00, 64'h11223344);

`ifdef I2CM_SEQ_RETRY_EN
        // address NACK twice, ACK on third attempt
        ex(K_SW, 8'h94, 1, 0, 0); ex(K_P, 0, 0, 0, 0);
        ex(K_SW, 8'h94, 1, 0, 0); ex(K_P, 0, 0, 0, 0);
        ex(K_SW, 8'h94, 0, 0, 0); ex(K_W, 8'h10, 0, 0, 0); ex(K_W, 8'h5A, 0, 0, 0); ex(K_P, 0, 0, 0, 0);
        run_req(1'b1, 7'h4A, 8'h10, 2'd0, 64'h5A, 2'b00, 64'h0);
        // retries exhausted: four attempts
        for (int i = 0; i < 4; i++) begin
            ex(K_SW, 8'h94, 1, 0, 0); ex(K_P, 0, 0, 0, 0);
        end
        run_req(1'b1, 7'h4A, 8'h10, 2'd0, 64'h5A, 2'b01, 64'h0);
`else
        // address NACK is terminal
        ex(K_SW, 8'h94, 1, 0, 0); ex(K_P, 0, 0, 0, 0);
        run_req(1'b1, 7'h4A, 8'h10, 2'd0, 64'h5A, 2'b01, 64'h0);
`endif

        // data NACK on second data byte of a 2-byte write
        ex(K_SW, 8'h66, 0, 0, 0); ex(K_W, 8'h05, 0, 0, 0); ex(K_W, 8'hAB, 0, 0, 0);
        ex(K_W, 8'hCD, 1, 0, 0); ex(K_P, 0, 0, 0, 0);
        run_req(1'b1, 7'h33, 8'h05, 2'd1, 64'hABCD, 2'b10, 64'h0);

        // arbitration lost coincident with register-byte ack
        ex(K_SW, 8'h94, 0, 0, 0); ex(K_W, 8'h30, 0, 0, 1);
        run_req(1'b0, 7'h4A, 8'h30, 2'd1, 64'h0, 2'b11, 64'h0);
        @(posedge mclk); #1;
        check("al_ready_after_2", 64'(req_ready), 64'd1);

        // 8-byte write, MSB byte first
        ex(K_SW, 8'hFE, 0, 0, 0); ex(K_W, 8'hFF, 0, 0, 0);
        for (int i = 1; i <= 8; i++) ex(K_W, 8'(i), 0, 0, 0);
        ex(K_P, 0, 0, 0, 0);
        run_req(1'b1, 7'h7F, 8'hFF, 2'd3, 64'h0102030405060708, 2'b00, 64'h0);

        // reset in the read-data phase
        ex(K_SW, 8'h94, 0, 0, 0); ex(K_W, 8'h21, 0, 0, 0); ex(K_P, 0, 0, 0, 0);
        ex(K_SW, 8'h95, 0, 0, 0); ex(K_RA, 0, 0, 8'h77, 0);
        issue(1'b0, 7'h4A, 8'h21, 2'd1, 64'h0);
        n = 0;
        while (!bc_read && n < 200) begin @(posedge mclk); #2; n++; end
        if (!bc_read) fail_now("rdata_phase_timeout");
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        check("mid_reset_cmds_seen", 64'(exp_cmd.size()), 64'd0);
        exp_cmd.delete(); plan.delete();
        repeat (2) @(posedge mclk);
        #3 reset_n = 1'b1;
        repeat (4) @(posedge mclk);
        #1;
        check("post_reset_ready", 64'(req_ready), 64'd1);

        // 1-byte read after reset
        ex(K_SW, 8'hA0, 0, 0, 0); ex(K_W, 8'h01, 0, 0, 0); ex(K_P, 0, 0, 0, 0);
        ex(K_SW, 8'hA1, 0, 0, 0); ex(K_RN, 0, 0, 8'hC3, 0); ex(K_P, 0, 0, 0, 0);
        run_req(1'b0, 7'h50, 8'h01, 2'd0, 64'h0, 2'b00, 64'hC3);

        repeat (5) @(posedge mclk);
        #1;
        check("final_idle", {63'h0, req_ready}, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
